nrx_rom_loader: RTL and testbench
=================================

NRX_ROM_LOADER -- requirements
Module: nrx_rom_loader

Interface
REQ-001 The block SHALL have parameter TAIL_CYCLES, default 16: cycles HOLD_RST stays high after a download ends.
REQ-002 The block SHALL have parameter ROM_BYTES, default 'h5200: expected image length in bytes.
REQ-003 The block SHALL have these ports:
- CLK24M  in  1  sole clock, 24 MHz system clock.
- RESET  in  1  asynchronous, active-high reset.
- DL_ACT  in  1  download in progress.
- DL_IDX  in  8  download index (0 = ROM image, 254 = DIP block).
- DL_WR  in  1  one-cycle byte strobe.
- DL_ADDR  in  25  byte address.
- DL_DATA  in  8  byte value.
- CPU_WE / GFX_WE / PROM_WE  out  1  region write strobes.
- REG_AD  out  14  region-local address.
- REG_DT  out  8  write data.
- DIPS  out  8  captured DIP byte.
- HOLD_RST  out  1  game core reset request.
- BUSY, DONE, ERR  out  1  status flags.
- CSUM  out  8  additive image checksum.

Function
REQ-004 The block SHALL implement states IDLE, LOAD, TAIL and READY.
- IDLE->LOAD when DL_ACT=1 and DL_IDX=0.
- LOAD->TAIL on DL_ACT falling.
- TAIL->READY after TAIL_CYCLES cycles.
- TAIL or READY ->LOAD on a new DL_ACT=1 with DL_IDX=0.
REQ-005 On entry to LOAD, the block SHALL clear the byte counter, ERR, DONE and CSUM.
REQ-006 In LOAD, each DL_WR with DL_IDX=0 SHALL produce exactly one region strobe one cycle later, with REG_AD and REG_DT registered alongside it.
REQ-007 The region map SHALL be:
- 'h0000-'h3FFF -> CPU_WE, REG_AD=ADDR[13:0].
- 'h4000-'h4FFF -> GFX_WE, REG_AD={2'b0,ADDR[11:0]}.
- 'h5000-'h51FF -> PROM_WE, REG_AD={5'b0,ADDR[8:0]}.
REQ-008 An address at or above 'h5200 SHALL produce no strobe and SHALL set ERR (sticky until the next LOAD entry).
REQ-009 Out-of-order and repeated addresses SHALL be written as presented; the byte counter SHALL count accepted in-map writes.
REQ-010 When DL_WR coincides with DL_ACT falling, the write SHALL still be processed, and the block SHALL enter TAIL on that same edge.
REQ-011 On the LOAD->TAIL transition, if the byte count is not equal to ROM_BYTES, the block SHALL set ERR.
REQ-012 HOLD_RST SHALL be 1 in IDLE, LOAD and TAIL, and 0 only in READY.
REQ-013 BUSY SHALL be 1 in LOAD and TAIL.
REQ-014 DONE SHALL pulse high for one cycle on TAIL->READY.
REQ-015 A DL_WR with DL_IDX=254 and DL_ADDR=0 SHALL load DIPS from DL_DATA in any state, with no region strobe and no change to the counter or CSUM.
REQ-016 A DL_WR with any other index SHALL be ignored.
REQ-017 At most one region strobe SHALL be high in any cycle.
REQ-018 The byte counter SHALL be 15 bits and SHALL saturate rather than wrap.

Reset
REQ-019 While RESET=1, the block SHALL be in IDLE with strobes=0, REG_AD=0, REG_DT=0, DIPS='h00, HOLD_RST=1, BUSY=0, DONE=0, ERR=0, CSUM=0 and counters=0.
REQ-020 RESET asserted mid-LOAD SHALL abort the load; after release the block SHALL wait in IDLE for a new download.

Configuration
REQ-021 With NRX_LOADER_CSUM_EN defined, CSUM SHALL be the modulo-256 sum of DL_DATA over all in-map writes of the current load, updated in the same cycle as the strobe.
REQ-022 Without NRX_LOADER_CSUM_EN, CSUM SHALL be constant 0 and no adder logic SHALL be present.

Structure
REQ-023 Shared package nrx_pkg SHALL hold:
- the state enum;
- region base/limit constants ('h0000, 'h4000, 'h5000, 'h5200);
- DIP_INDEX=254 and ROM_INDEX=0.
REQ-024 A sub-module nrx_region_dec SHALL provide the combinational address-to-region/offset decoder; everything else SHALL stay in one module.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Full load of 'h5200 sequential bytes, data=ADDR[7:0] -> 16384 CPU_WE, 4096 GFX_WE and 512 PROM_WE strobes; ERR=0; DONE one cycle, 16 cycles after DL_ACT falls; CSUM='h00.
- Write to 'h5200 mid-load -> no strobe; ERR=1 through READY.
- Load stopped at 'h4FFF -> ERR=1 at TAIL entry; HOLD_RST still drops after 16 cycles.
- DIP write idx 254, addr 0, data 'hA5 during LOAD -> DIPS='hA5; counter and CSUM unchanged; no strobe.
- RESET pulse at byte 'h1234 -> all outputs reach reset values immediately; a new full load then completes with ERR=0.
- DL_ACT re-asserted on TAIL cycle 5 -> back to LOAD; counter cleared; HOLD_RST never drops.

Source files
------------

// File: rtl/nrx_pkg.sv
// Shared types and constants for the NRX ROM loader.
// The address map below describes the downloaded image layout:
// CPU program, then graphics, then colour PROMs, then end of image.
package nrx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TAIL,
    ST_READY
  } nrx_state_e;

  localparam logic [24:0] CPU_BASE  = 25'h000_0000;
  localparam logic [24:0] GFX_BASE  = 25'h000_4000;
  localparam logic [24:0] PROM_BASE = 25'h000_5000;
  localparam logic [24:0] ROM_LIMIT = 25'h000_5200;

  localparam logic [7:0] ROM_INDEX = 8'd0;
  localparam logic [7:0] DIP_INDEX = 8'd254;

endpackage

// File: rtl/nrx_region_dec.sv
// Combinational byte-address decoder for the NRX image.
// Reports which region a download address falls into and the
// region-local offset. No hit bit is set for addresses past the image.
module nrx_region_dec
  import nrx_pkg::*;
(
  input  logic [24:0] addr_i,
  output logic        cpuHit_o,
  output logic        gfxHit_o,
  output logic        promHit_o,
  output logic [13:0] offset_o
);

  logic [24:0] cpuRel;

  // Range compare against the region bounds; regions are aligned so the offset is a bit slice
  always_comb begin
    cpuHit_o  = 1'b0;
    gfxHit_o  = 1'b0;
    promHit_o = 1'b0;
    offset_o  = '0;
    cpuRel    = addr_i - CPU_BASE;
    if (cpuRel < (GFX_BASE - CPU_BASE)) begin
      cpuHit_o = 1'b1;
      offset_o = cpuRel[13:0];
    end else if ((addr_i >= GFX_BASE) && (addr_i < PROM_BASE)) begin
      gfxHit_o = 1'b1;
      offset_o = {2'b00, addr_i[11:0]};
    end else if ((addr_i >= PROM_BASE) && (addr_i < ROM_LIMIT)) begin
      promHit_o = 1'b1;
      offset_o  = {5'b00000, addr_i[8:0]};
    end
  end

endmodule

// File: rtl/nrx_rom_loader.sv
// NRX ROM loader: steers a byte-serial download into CPU, GFX and PROM
// write strobes, captures the DIP byte, and holds the game core in reset
// until the image has landed plus a short settling tail.
// Optional feature: define NRX_LOADER_CSUM_EN to enable the additive
// image checksum on CSUM; otherwise CSUM is tied to zero.
module nrx_rom_loader
  import nrx_pkg::*;
#(
  parameter int TAIL_CYCLES = 16,
  parameter int ROM_BYTES   = 'h5200
) (
  input  logic        CLK24M,
  input  logic        RESET,
  input  logic        DL_ACT,
  input  logic [7:0]  DL_IDX,
  input  logic        DL_WR,
  input  logic [24:0] DL_ADDR,
  input  logic [7:0]  DL_DATA,
  output logic        CPU_WE,
  output logic        GFX_WE,
  output logic        PROM_WE,
  output logic [13:0] REG_AD,
  output logic [7:0]  REG_DT,
  output logic [7:0]  DIPS,
  output logic        HOLD_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  CSUM
);

  nrx_state_e  state_q, state_d;
  logic [14:0] byteCnt_q, byteCnt_d;
  logic [15:0] tailCnt_q, tailCnt_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        cpuWe_q, cpuWe_d;
  logic        gfxWe_q, gfxWe_d;
  logic        promWe_q, promWe_d;
  logic [13:0] regAd_q, regAd_d;
  logic [7:0]  regDt_q, regDt_d;
  logic [7:0]  dips_q, dips_d;

  logic        cpuHit, gfxHit, promHit, inMap;
  logic [13:0] regOffset;
  logic        loadReq;
  logic        enterLoad;
  logic        acceptWr;

  nrx_region_dec u_dec (
    .addr_i    (DL_ADDR),
    .cpuHit_o  (cpuHit),
    .gfxHit_o  (gfxHit),
    .promHit_o (promHit),
    .offset_o  (regOffset)
  );

  assign inMap   = cpuHit | gfxHit | promHit;
  assign loadReq = DL_ACT && (DL_IDX == ROM_INDEX);

  // Next-state logic: write steering first so the TAIL-entry length check sees a coincident final byte
  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    tailCnt_d = tailCnt_q;
    err_d     = err_q;
    done_d    = 1'b0;
    cpuWe_d   = 1'b0;
    gfxWe_d   = 1'b0;
    promWe_d  = 1'b0;
    regAd_d   = regAd_q;
    regDt_d   = regDt_q;
    dips_d    = dips_q;
    enterLoad = 1'b0;
    acceptWr  = 1'b0;

    if (DL_WR && (DL_IDX == DIP_INDEX) && (DL_ADDR == 25'd0)) begin
      dips_d = DL_DATA;
    end

    if ((state_q == ST_LOAD) && DL_WR && (DL_IDX == ROM_INDEX)) begin
      if (inMap) begin
        acceptWr = 1'b1;
        cpuWe_d  = cpuHit;
        gfxWe_d  = gfxHit;
        promWe_d = promHit;
        regAd_d  = regOffset;
        regDt_d  = DL_DATA;
        if (byteCnt_q != 15'h7FFF) begin
          byteCnt_d = byteCnt_q + 15'd1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (loadReq) begin
          enterLoad = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!DL_ACT) begin
          state_d   = ST_TAIL;
          tailCnt_d = '0;
          if (byteCnt_d != 15'(ROM_BYTES)) begin
            err_d = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (loadReq) begin
          enterLoad = 1'b1;
        end else if (tailCnt_q == 16'(TAIL_CYCLES - 1)) begin
          state_d = ST_READY;
          done_d  = 1'b1;
        end else begin
          tailCnt_d = tailCnt_q + 16'd1;
        end
      end
      ST_READY: begin
        if (loadReq) begin
          enterLoad = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (enterLoad) begin
      state_d   = ST_LOAD;
      byteCnt_d = '0;
      tailCnt_d = '0;
      err_d     = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset
  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      byteCnt_q <= '0;
      tailCnt_q <= '0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      cpuWe_q   <= 1'b0;
      gfxWe_q   <= 1'b0;
      promWe_q  <= 1'b0;
      regAd_q   <= '0;
      regDt_q   <= '0;
      dips_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      tailCnt_q <= tailCnt_d;
      err_q     <= err_d;
      done_q    <= done_d;
      cpuWe_q   <= cpuWe_d;
      gfxWe_q   <= gfxWe_d;
      promWe_q  <= promWe_d;
      regAd_q   <= regAd_d;
      regDt_q   <= regDt_d;
      dips_q    <= dips_d;
    end
  end

`ifdef NRX_LOADER_CSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running modulo-256 sum of accepted image bytes, restarted with each new load
  always_comb begin
    csum_d = csum_q;
    if (enterLoad) begin
      csum_d = 8'h00;
    end else if (acceptWr) begin
      csum_d = csum_q + DL_DATA;
    end
  end

  // Checksum register, updated on the same edge that registers the strobe
  always_ff @(posedge CLK24M or posedge RESET) begin
    if (RESET) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign CSUM = csum_q;
`else
  assign CSUM = 8'h00;
`endif

  assign CPU_WE   = cpuWe_q;
  assign GFX_WE   = gfxWe_q;
  assign PROM_WE  = promWe_q;
  assign REG_AD   = regAd_q;
  assign REG_DT   = regDt_q;
  assign DIPS     = dips_q;
  assign HOLD_RST = (state_q != ST_READY);
  assign BUSY     = (state_q == ST_LOAD) || (state_q == ST_TAIL);
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_nrx_rom_loader.sv
// Self-checking bench for nrx_rom_loader: directed scenarios plus a
// randomized download, with a queue-based scoreboard for region strobes.
`timescale 1ns/1ps
module tb_nrx_rom_loader;

  logic        CLK24M  = 1'b0;
  logic        RESET   = 1'b0;
  logic        DL_ACT  = 1'b0;
  logic [7:0]  DL_IDX  = 8'd0;
  logic        DL_WR   = 1'b0;
  logic [24:0] DL_ADDR = '0;
  logic [7:0]  DL_DATA = 8'd0;
  logic        CPU_WE, GFX_WE, PROM_WE;
  logic [13:0] REG_AD;
  logic [7:0]  REG_DT, DIPS, CSUM;
  logic        HOLD_RST, BUSY, DONE, ERR;

  nrx_rom_loader #(.TAIL_CYCLES(16), .ROM_BYTES('h5200)) dut (
    .CLK24M(CLK24M), .RESET(RESET), .DL_ACT(DL_ACT), .DL_IDX(DL_IDX),
    .DL_WR(DL_WR), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA),
    .CPU_WE(CPU_WE), .GFX_WE(GFX_WE), .PROM_WE(PROM_WE),
    .REG_AD(REG_AD), .REG_DT(REG_DT), .DIPS(DIPS), .HOLD_RST(HOLD_RST),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
  );

  always #21 CLK24M = ~CLK24M;

`ifdef NRX_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  we;
    logic [13:0] ad;
    logic [7:0]  dt;
  } exp_t;

  exp_t sbQ[$];
  exp_t monExp;
  logic [2:0] monWe;

  int vectors = 0;
  int miscompares = 0;
  int seenCpu = 0, seenGfx = 0, seenProm = 0;

  bit         mLoading = 1'b0;
  int         mCount = 0;
  bit         mErr = 1'b0;
  logic [7:0] mCsum = 8'h00;
  logic [7:0] mDips = 8'h00;

  // One comparison: counts it, reports a FAIL line when it does not hold
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] expCsum();
    return CSUM_EN ? mCsum : 8'h00;
  endfunction

  // Reference model of one byte strobe, written from the address map rules
  function automatic void modelWrite(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data);
    exp_t e;
    logic [24:0] off;
    bit hit;
    hit = 1'b0;
    if (idx == 8'd254 && addr == 25'd0) begin
      mDips = data;
    end else if (idx == 8'd0 && mLoading) begin
      if (addr < 25'h4000) begin
        off = addr; e.we = 3'b100; hit = 1'b1;
      end else if (addr < 25'h5000) begin
        off = addr - 25'h4000; e.we = 3'b010; hit = 1'b1;
      end else if (addr < 25'h5200) begin
        off = addr - 25'h5000; e.we = 3'b001; hit = 1'b1;
      end else begin
        off = '0; mErr = 1'b1;
      end
      if (hit) begin
        e.ad = off[13:0];
        e.dt = data;
        sbQ.push_back(e);
        if (mCount < 32767) mCount++;
        mCsum = mCsum + data;
      end
    end
  endfunction

  task automatic tick();
    @(posedge CLK24M);
    #1;
  endtask

  task automatic atNeg();
    @(negedge CLK24M);
  endtask

  // Drive one byte strobe; keepAct=0 drops DL_ACT on the same edge
  task automatic applyStimulus(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] data, input bit keepAct);
    DL_IDX  = idx;
    DL_ADDR = addr;
    DL_DATA = data;
    DL_WR   = 1'b1;
    DL_ACT  = keepAct ? DL_ACT : 1'b0;
    modelWrite(idx, addr, data);
    tick();
    DL_WR  = 1'b0;
    DL_IDX = 8'd0;
    if (!keepAct && mLoading) begin
      mLoading = 1'b0;
      if (mCount != 'h5200) mErr = 1'b1;
    end
  endtask

  task automatic startLoad();
    DL_ACT = 1'b1;
    DL_IDX = 8'd0;
    tick();
    mLoading = 1'b1;
    mCount = 0;
    mErr = 1'b0;
    mCsum = 8'h00;
    seenCpu = 0; seenGfx = 0; seenProm = 0;
  endtask

  task automatic endLoad();
    DL_ACT = 1'b0;
    tick();
    mLoading = 1'b0;
    if (mCount != 'h5200) mErr = 1'b1;
  endtask

  task automatic loadRange(input int first, input int last);
    for (int a = first; a <= last; a++) begin
      applyStimulus(8'd0, 25'(a), 8'(a), 1'b1);
    end
  endtask

  // Watch the tail after DL_ACT fell: ERR at entry, DONE timing/width, HOLD_RST release
  task automatic checkTail(input string tag);
    int doneAt = -1;
    int doneCnt = 0;
    int holdDrop = -1;
    logic errEntry = 1'b0;
    for (int n = 0; n < 24; n++) begin
      atNeg();
      if (n == 0) errEntry = ERR;
      if (DONE) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      if (!HOLD_RST && holdDrop < 0) holdDrop = n;
      tick();
    end
    checkOutput({tag, "_err_at_tail"}, 32'(errEntry), 32'(mErr));
    checkOutput({tag, "_done_cycle"}, doneAt, 16);
    checkOutput({tag, "_done_width"}, doneCnt, 1);
    checkOutput({tag, "_hold_drop"}, holdDrop, 16);
    atNeg();
    checkOutput({tag, "_err_ready"}, 32'(ERR), 32'(mErr));
    checkOutput({tag, "_busy_ready"}, 32'(BUSY), 0);
    checkOutput({tag, "_csum"}, 32'(CSUM), 32'(expCsum()));
    checkOutput({tag, "_sb_drained"}, sbQ.size(), 0);
  endtask

  task automatic checkResetVals(input string tag);
    checkOutput({tag, "_we"}, {29'd0, CPU_WE, GFX_WE, PROM_WE}, 0);
    checkOutput({tag, "_reg_ad"}, 32'(REG_AD), 0);
    checkOutput({tag, "_reg_dt"}, 32'(REG_DT), 0);
    checkOutput({tag, "_dips"}, 32'(DIPS), 0);
    checkOutput({tag, "_hold"}, 32'(HOLD_RST), 1);
    checkOutput({tag, "_busy"}, 32'(BUSY), 0);
    checkOutput({tag, "_done"}, 32'(DONE), 0);
    checkOutput({tag, "_err"}, 32'(ERR), 0);
    checkOutput({tag, "_csum"}, 32'(CSUM), 0);
  endtask

  // Scoreboard monitor: every presented strobe must match the oldest expected write
  always @(negedge CLK24M) begin
    if (!RESET) begin
      monWe = {CPU_WE, GFX_WE, PROM_WE};
      if (monWe != 3'b000) begin
        checkOutput("one_strobe", 32'($countones(monWe) <= 1), 1);
        if (CPU_WE) seenCpu++;
        if (GFX_WE) seenGfx++;
        if (PROM_WE) seenProm++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_strobe", {7'd0, monWe, REG_AD, REG_DT}, 0);
        end else begin
          monExp = sbQ.pop_front();
          checkOutput("strobe", {7'd0, monWe, REG_AD, REG_DT}, {7'd0, monExp});
        end
      end
    end
  end

  initial begin
    logic [24:0] rAddr;
    int r;

    #2 RESET = 1'b1;
    tick(); tick(); tick();
    atNeg();
    checkResetVals("reset");
    tick();
    RESET = 1'b0;
    tick();

    // DIP capture in IDLE, and a ROM-index byte outside a download is ignored
    applyStimulus(8'd254, 25'd0, 8'h5A, 1'b0);
    applyStimulus(8'd0, 25'h10, 8'h11, 1'b0);
    atNeg();
    checkOutput("idle_dips", 32'(DIPS), 32'(mDips));
    checkOutput("idle_busy", 32'(BUSY), 0);
    checkOutput("idle_hold", 32'(HOLD_RST), 1);
    tick();

    // Full sequential image, last byte coincident with DL_ACT falling
    startLoad();
    loadRange(0, 'h51FE);
    applyStimulus(8'd0, 25'h51FF, 8'hFF, 1'b0);
    checkTail("full");
    checkOutput("full_cpu_count", seenCpu, 16384);
    checkOutput("full_gfx_count", seenGfx, 4096);
    checkOutput("full_prom_count", seenProm, 512);
    checkOutput("full_hold_ready", 32'(HOLD_RST), 0);
    tick();

    // Out-of-map byte mid-load: no strobe, ERR raised immediately and kept
    startLoad();
    loadRange(0, 'h3F);
    applyStimulus(8'd0, 25'h5200, 8'h77, 1'b1);
    atNeg();
    checkOutput("ovf_err_now", 32'(ERR), 32'(mErr));
    checkOutput("ovf_busy", 32'(BUSY), 1);
    tick();
    loadRange('h40, 'h7F);
    endLoad();
    checkTail("ovf");

    // Image cut short at 'h4FFF: ERR only at TAIL entry
    startLoad();
    loadRange(0, 'h4FFF);
    atNeg();
    checkOutput("short_err_before", 32'(ERR), 0);
    tick();
    endLoad();
    checkTail("short");

    // Reset mid-load aborts everything at once
    startLoad();
    loadRange(0, 'hFFF);
    applyStimulus(8'd254, 25'd0, 8'h3C, 1'b1);
    loadRange('h1000, 'h1234);
    tick(); tick();
    checkOutput("rst_sb_drained", sbQ.size(), 0);
    sbQ.delete();
    #5 RESET = 1'b1;
    DL_ACT = 1'b0;
    #1 checkResetVals("midrst");
    mLoading = 1'b0; mErr = 1'b0; mCsum = 8'h00; mDips = 8'h00; mCount = 0;
    tick(); tick();
    RESET = 1'b0;
    tick(); tick(); tick();
    atNeg();
    checkOutput("postrst_hold", 32'(HOLD_RST), 1);
    checkOutput("postrst_busy", 32'(BUSY), 0);
    tick();

    // Short load, then DL_ACT re-asserted on TAIL cycle 5; HOLD_RST must stay up
    startLoad();
    loadRange(0, 15);
    endLoad();
    for (int i = 0; i < 5; i++) begin
      atNeg();
      checkOutput("retail_hold", 32'(HOLD_RST), 1);
      checkOutput("retail_busy", 32'(BUSY), 1);
      tick();
    end
    startLoad();
    atNeg();
    checkOutput("reload_hold", 32'(HOLD_RST), 1);
    checkOutput("reload_busy", 32'(BUSY), 1);
    checkOutput("reload_err_clear", 32'(ERR), 0);
    checkOutput("reload_csum_clear", 32'(CSUM), 0);
    tick();
    loadRange(0, 'h1FFF);
    applyStimulus(8'd254, 25'd0, 8'hA5, 1'b1);
    atNeg();
    checkOutput("dip_value", 32'(DIPS), 32'hA5);
    checkOutput("dip_csum", 32'(CSUM), 32'(expCsum()));
    tick();
    loadRange('h2000, 'h51FF);
    endLoad();
    checkTail("reload");

    // Randomized download: mixed indices, gaps, occasional out-of-map bytes
    startLoad();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        tick();
      end else if (r == 1) begin
        applyStimulus(8'($urandom_range(1, 253)), 25'($urandom_range(0, 'h51FF)), 8'($urandom), 1'b1);
      end else if (r == 2) begin
        applyStimulus(8'd254, 25'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end else if (r == 3) begin
        rAddr = 25'h5200 + 25'($urandom_range(0, 'h1FF_0000));
        applyStimulus(8'd0, rAddr, 8'($urandom), 1'b1);
      end else begin
        applyStimulus(8'd0, 25'($urandom_range(0, 'h51FF)), 8'($urandom), 1'b1);
      end
    end
    tick();
    atNeg();
    checkOutput("rand_err", 32'(ERR), 32'(mErr));
    checkOutput("rand_csum", 32'(CSUM), 32'(expCsum()));
    checkOutput("rand_dips", 32'(DIPS), 32'(mDips));
    tick();
    endLoad();
    checkTail("rand");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
